// File: rtl/imem_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_access_arbiter_pkg
// Description : Shared constants, owner/state encodings and the address range
//               helper for the instruction-memory access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_access_arbiter_pkg;

  // Byte address of word 0 of the instruction memory
  localparam logic [31:0] c_I_MEM_START_ADDR = 32'h0000_0000;
  // Instruction returned for out-of-range fetches (addi x0, x0, 0)
  localparam logic [31:0] c_NOP_INSN         = 32'h0000_0013;

  // Port identifiers used by the round-robin pointer
  localparam logic c_PORT_F = 1'b0;
  localparam logic c_PORT_L = 1'b1;

  // Owner of the read response due in the next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_L    = 2'd2
  } owner_e;

  // Top-level phase: loader-only boot, then shared operation
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Unsigned word-offset compare; an address below base wraps to a huge
  // offset and therefore falls out of range.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth);
    logic [31:0] w_off;
    logic [31:0] w_word;
    w_off  = addr - base;
    w_word = w_off >> 2;
    return (w_word < depth);
  endfunction

endpackage : imem_access_arbiter_pkg
`default_nettype wire

// File: rtl/imem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : imem_rr_pick
// Description : Two-way round-robin selector. A lone request is granted; on
//               contention the port that was not granted last wins.
//               Bit 0 = fetch port, bit 1 = loader port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Pick the requester; on a tie favour the port opposite the pointer
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b01 : 2'b10;
    end
  end

endmodule : imem_rr_pick
`default_nettype wire

// File: rtl/imem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_access_arbiter
// Description : Shares a single-port synchronous instruction memory between
//               the fetch stage (read-only) and the loader/debug port.
//               Loader-only boot phase, then round-robin arbitration with
//               1-cycle read-response routing and fetch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_access_arbiter
  import imem_access_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = c_I_MEM_START_ADDR,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INSN  = c_NOP_INSN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boot_done,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic        f_flush,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e     r_state;
  state_e     w_state_next;
  logic       r_rr_ptr;
  owner_e     r_pend_owner;
  logic       r_pend_err;
  owner_e     w_pend_owner_next;
  logic       w_pend_err_next;
  logic [1:0] w_rr_gnt;
  logic       w_f_in_range;
  logic       w_l_in_range;
  logic       w_contention;

  assign w_f_in_range = addr_in_range(f_addr, BASE_ADDR, MEM_DEPTH);
  assign w_l_in_range = addr_in_range(l_addr, BASE_ADDR, MEM_DEPTH);
  assign w_contention = (r_state == ST_RUN) && f_req && l_req;

  imem_rr_pick u_rr_pick (
    .req (({l_req, f_req})),
    .ptr (r_rr_ptr),
    .gnt (w_rr_gnt)
  );

  // Phase register: BOOT until the loader releases the memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next phase and grants; nothing is granted while reset is held
  always_comb begin
    w_state_next = r_state;
    f_gnt        = 1'b0;
    l_gnt        = 1'b0;
    if (!reset) begin
      if (r_state == ST_RUN) begin
        f_gnt = w_rr_gnt[0];
        l_gnt = w_rr_gnt[1];
      end else begin
        l_gnt = l_req;
        if (boot_done && !l_req) begin
          w_state_next = ST_RUN;
        end
      end
    end
  end

  // Round-robin pointer remembers the winner of the last contended cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= c_PORT_F;
    end else if (w_contention) begin
      r_rr_ptr <= w_rr_gnt[1] ? c_PORT_L : c_PORT_F;
    end
  end

  // Memory command mux and owner of the response due next cycle
  always_comb begin
    mem_en            = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = {l_addr[31:2], 2'b00};
    mem_wdata         = l_wdata;
    w_pend_owner_next = OWN_NONE;
    w_pend_err_next   = 1'b0;
    if (f_gnt) begin
      mem_en            = w_f_in_range;
      mem_addr          = {f_addr[31:2], 2'b00};
      w_pend_owner_next = OWN_F;
      w_pend_err_next   = !w_f_in_range;
    end else if (l_gnt) begin
      mem_en = w_l_in_range;
      mem_we = w_l_in_range && l_we;
      if (!l_we) begin
        w_pend_owner_next = OWN_L;
        w_pend_err_next   = !w_l_in_range;
      end
    end
  end

  // Pending-response register used to route read data one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_owner <= OWN_NONE;
      r_pend_err   <= 1'b0;
    end else begin
      r_pend_owner <= w_pend_owner_next;
      r_pend_err   <= w_pend_err_next;
    end
  end

  // A flush in the response cycle kills only the fetch response
  assign f_rvalid = (r_pend_owner == OWN_F) && !f_flush;
  assign f_err    = f_rvalid && r_pend_err;
  assign f_rdata  = r_pend_err ? NOP_INSN : mem_rdata;
  assign l_rvalid = (r_pend_owner == OWN_L);
  assign l_rdata  = r_pend_err ? 32'h0000_0000 : mem_rdata;

endmodule : imem_access_arbiter
`default_nettype wire

// File: tb/tb_imem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_access_arbiter
// Description : Self-checking bench: directed scenarios with literal values,
//               then randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_access_arbiter;

  localparam logic [31:0] TB_BASE  = 32'h0000_0000;
  localparam int          TB_DEPTH = 16;
  localparam logic [31:0] TB_NOP   = 32'h0000_0013;

  logic        clk, reset, boot_done;
  logic        f_req, f_flush, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_gnt, l_rvalid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  imem_access_arbiter #(
    .BASE_ADDR (TB_BASE),
    .MEM_DEPTH (TB_DEPTH),
    .NOP_INSN  (TB_NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .boot_done (boot_done),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_flush   (f_flush),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .f_err     (f_err),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(input int i);
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - TB_BASE) >> 2) % TB_DEPTH);
  endfunction

  // Plain arithmetic range test, no wrap games
  function automatic logic in_rng(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(TB_BASE);
    return (la >= lb) && (la < lb + 4 * TB_DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Synchronous single-port memory macro
  logic [31:0] macro_mem [TB_DEPTH];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < TB_DEPTH; i++) macro_mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) macro_mem[widx(mem_addr)] <= mem_wdata;
      else        mem_rdata <= macro_mem[widx(mem_addr)];
    end
  end

  // Behavioural model state
  logic [31:0] ref_mem [TB_DEPTH];
  logic        m_run, m_last_l;
  logic        m_fv, m_fe, m_lv;
  logic [31:0] m_fd, m_ld;
  logic        last_f_gnt, last_l_gnt;

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    logic eg_f, eg_l, e_en, fin, lin;
    if (reset) begin
      chk("rst_f_gnt", 32'(f_gnt), 0);
      chk("rst_l_gnt", 32'(l_gnt), 0);
      chk("rst_f_rvalid", 32'(f_rvalid), 0);
      chk("rst_l_rvalid", 32'(l_rvalid), 0);
      chk("rst_f_err", 32'(f_err), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      m_run    <= 1'b0;
      m_last_l <= 1'b0;
      m_fv     <= 1'b0;
      m_lv     <= 1'b0;
    end else begin
      fin = in_rng(f_addr);
      lin = in_rng(l_addr);
      if (!m_run) begin
        eg_f = 1'b0;
        eg_l = l_req;
      end else if (f_req && l_req) begin
        eg_l = !m_last_l;
        eg_f = m_last_l;
      end else begin
        eg_f = f_req;
        eg_l = l_req;
      end
      chk("f_gnt", 32'(f_gnt), 32'(eg_f));
      chk("l_gnt", 32'(l_gnt), 32'(eg_l));
      e_en = (eg_f && fin) || (eg_l && lin);
      chk("mem_en", 32'(mem_en), 32'(e_en));
      if (e_en) begin
        chk("mem_addr", mem_addr, eg_f ? (f_addr & ~32'h3) : (l_addr & ~32'h3));
        chk("mem_we", 32'(mem_we), 32'(eg_l && l_we));
        if (eg_l && l_we) chk("mem_wdata", mem_wdata, l_wdata);
      end else begin
        chk("mem_we_idle", 32'(mem_we), 0);
      end
      chk("f_rvalid", 32'(f_rvalid), 32'(m_fv && !f_flush));
      if (m_fv && !f_flush) begin
        chk("f_rdata", f_rdata, m_fd);
        chk("f_err", 32'(f_err), 32'(m_fe));
      end else begin
        chk("f_err_idle", 32'(f_err), 0);
      end
      chk("l_rvalid", 32'(l_rvalid), 32'(m_lv));
      if (m_lv) chk("l_rdata", l_rdata, m_ld);

      m_fv <= eg_f;
      m_fe <= !fin;
      m_fd <= fin ? ref_mem[widx(f_addr)] : TB_NOP;
      m_lv <= eg_l && !l_we;
      m_ld <= lin ? ref_mem[widx(l_addr)] : 32'h0;
      if (eg_l && l_we && lin) ref_mem[widx(l_addr)] <= l_wdata;
      if (m_run && f_req && l_req) m_last_l <= eg_l;
      if (!m_run && boot_done && !eg_l) m_run <= 1'b1;
    end
    last_f_gnt <= f_gnt;
    last_l_gnt <= l_gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < TB_DEPTH; i++) ref_mem[i] = init_val(i);
    reset = 1'b1; boot_done = 1'b0;
    f_req = 1'b1; f_addr = 32'h4; f_flush = 1'b0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
    step(); step();
    #3;
    chk("lit_rst_l_gnt", 32'(l_gnt), 0);
    chk("lit_rst_mem_en", 32'(mem_en), 0);

    // Boot: loader writes, fetch held off
    step();
    reset = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'hAAAA_0001;
    #3;
    chk("lit_boot_l_gnt", 32'(l_gnt), 1);
    chk("lit_boot_f_gnt", 32'(f_gnt), 0);
    chk("lit_boot_mem_we", 32'(mem_we), 1);
    step();
    l_addr = 32'h4; l_wdata = 32'hAAAA_0002;
    #3;
    chk("lit_boot_wdata", mem_wdata, 32'hAAAA_0002);
    chk("lit_boot_f_gnt2", 32'(f_gnt), 0);
    step();
    l_req = 1'b0;
    #3;
    chk("lit_boot_f_gnt3", 32'(f_gnt), 0);
    step();
    f_req = 1'b0; boot_done = 1'b1;

    // Solo fetch in RUN
    step();
    f_req = 1'b1; f_addr = 32'h4;
    #3;
    chk("lit_run_f_gnt", 32'(f_gnt), 1);
    step();
    f_req = 1'b0;
    #3;
    chk("lit_solo_rvalid", 32'(f_rvalid), 1);
    chk("lit_solo_rdata", f_rdata, 32'hAAAA_0002);

    // Contention: expect L, F, L, F
    step();
    f_req = 1'b1; f_addr = 32'h4; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("lit_cont_l_gnt", 32'(l_gnt), 32'((k % 2) == 0));
      step();
    end
    f_req = 1'b0; l_req = 1'b0;
    #3;
    chk("lit_cont_f_rdata", f_rdata, 32'hAAAA_0002);

    // Flush kills only the older fetch
    step();
    f_req = 1'b1; f_addr = 32'h0;
    #3;
    chk("lit_flush_gnt0", 32'(f_gnt), 1);
    step();
    f_flush = 1'b1; f_addr = 32'h4;
    #3;
    chk("lit_flush_rvalid", 32'(f_rvalid), 0);
    chk("lit_flush_gnt1", 32'(f_gnt), 1);
    step();
    f_flush = 1'b0; f_req = 1'b0;
    #3;
    chk("lit_flush_rvalid2", 32'(f_rvalid), 1);
    chk("lit_flush_rdata", f_rdata, 32'hAAAA_0002);

    // Out-of-range fetch
    step();
    f_req = 1'b1; f_addr = TB_BASE + 4 * TB_DEPTH;
    #3;
    chk("lit_range_gnt", 32'(f_gnt), 1);
    chk("lit_range_mem_en", 32'(mem_en), 0);
    step();
    f_req = 1'b0;
    #3;
    chk("lit_range_err", 32'(f_err), 1);
    chk("lit_range_rdata", f_rdata, 32'h0000_0013);

    // Reset right after a granted read
    step();
    f_req = 1'b1; f_addr = 32'h0;
    #3;
    chk("lit_rmr_gnt", 32'(f_gnt), 1);
    step();
    f_req = 1'b0; reset = 1'b1; boot_done = 1'b0;
    #3;
    chk("lit_rmr_rvalid", 32'(f_rvalid), 0);
    step();
    reset = 1'b0; f_req = 1'b1;
    #3;
    chk("lit_rmr_f_gnt", 32'(f_gnt), 0);
    chk("lit_rmr_rvalid2", 32'(f_rvalid), 0);

    // Randomized traffic; requesters hold fields until granted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      reset     = (cyc >= 1500) && (cyc < 1502);
      boot_done = (cyc % 1500) >= 40;
      if (!(f_req && !last_f_gnt) || reset) begin
        f_req  = ($urandom % 3) != 0;
        f_addr = ($urandom_range(0, 18) == 18) ? 32'hFFFF_FFF0
               : ((32'($urandom_range(0, 17)) << 2) | 32'($urandom_range(0, 3)));
      end
      if (!(l_req && !last_l_gnt) || reset) begin
        l_req   = ($urandom % 2) != 0;
        l_we    = ($urandom % 2) != 0;
        l_addr  = (32'($urandom_range(0, 17)) << 2);
        l_wdata = $urandom;
      end
      f_flush = ($urandom % 5) == 0;
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_imem_access_arbiter
`default_nettype wire
